mysystem_onchip_arbiter: RTL

//  Two-master Avalon-MM arbiter sharing the single-port 2048x32 on-chip RAM.
//  m0 = Nios data master, m1 = OV7670 capture/stream master.

---
 rtl/mysystem_onchip_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mysystem_onchip_arbiter.sv
// Two-master Avalon-MM arbiter in front of a single-port 2048x32 on-chip RAM.
// Round-robin with bounded burst hold by default; ONCHIP_ARB_FIXED_PRIO_EN selects fixed m0 priority.
module mysystem_onchip_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int BE_W      = 4,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);

    logic req0;
    logic req1;
    logic grant0;
    logic grant1;
    logic rd_pend_reg;
    logic rd_pend_next;
    logic rd_id_reg;
    logic rd_id_next;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef ONCHIP_ARB_FIXED_PRIO_EN
    // m1 only gets the RAM in cycles where m0 is not asking for it.
    always_comb begin
        grant0 = ~reset & req0;
        grant1 = ~reset & req1 & ~req0;
    end
`else
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic             rr_ptr_reg;
    logic             rr_ptr_next;
    logic [CNT_W-1:0] burst_cnt_reg;
    logic [CNT_W-1:0] burst_cnt_next;
    logic [CNT_W-1:0] burst_cnt_inc;

    assign burst_cnt_inc = (burst_cnt_reg == BURST_LAST) ? BURST_LAST
                                                         : burst_cnt_reg + CNT_W'(1);

    always_comb begin
        grant0         = 1'b0;
        grant1         = 1'b0;
        state_next     = IDLE;
        burst_cnt_next = '0;
        rr_ptr_next    = rr_ptr_reg;
        case (state_reg)
            OWN0: begin
                if (req0 && (burst_cnt_reg < BURST_LAST || !req1)) grant0 = 1'b1;
                else if (req1)                                    grant1 = 1'b1;
            end
            OWN1: begin
                if (req1 && (burst_cnt_reg < BURST_LAST || !req0)) grant1 = 1'b1;
                else if (req0)                                    grant0 = 1'b1;
            end
            default: begin
                if (req0 && req1) begin
                    grant0 = ~rr_ptr_reg;
                    grant1 = rr_ptr_reg;
                end else begin
                    grant0 = req0;
                    grant1 = req1;
                end
            end
        endcase
        if (reset) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
        // The burst counter only advances while the same master keeps the grant.
        if (grant0) begin
            state_next     = OWN0;
            burst_cnt_next = (state_reg == OWN0) ? burst_cnt_inc : '0;
            rr_ptr_next    = 1'b1;
        end else if (grant1) begin
            state_next     = OWN1;
            burst_cnt_next = (state_reg == OWN1) ? burst_cnt_inc : '0;
            rr_ptr_next    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= 1'b0;
            burst_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end
`endif

    // A simultaneous read+write is treated as a write, so it never produces read data.
    assign rd_pend_next = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);
    assign rd_id_next   = grant1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pend_reg <= 1'b0;
            rd_id_reg   <= 1'b0;
        end else begin
            rd_pend_reg <= rd_pend_next;
            rd_id_reg   <= rd_id_next;
        end
    end

    assign m0_waitrequest   = ~grant0;
    assign m1_waitrequest   = ~grant1;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = rd_pend_reg & ~rd_id_reg;
    assign m1_readdatavalid = rd_pend_reg & rd_id_reg;

    assign ram_address    = grant1 ? m1_address    : m0_address;
    assign ram_byteenable = grant1 ? m1_byteenable : m0_byteenable;
    assign ram_writedata  = grant1 ? m1_writedata  : m0_writedata;
    assign ram_write      = (grant0 & m0_write) | (grant1 & m1_write);
    assign ram_chipselect = grant0 | grant1;
    assign ram_clken      = ~reset;

endmodule
